// File: rtl/hash160_stream_ctrl.sv
// hash160_stream_ctrl
//   Byte-stream front end and sequencer for HASH160 = RIPEMD160(SHA256(msg)).
//   Collects IN_BYTES-wide beats into a 64-byte block buffer, applies SHA-256
//   padding on the fly, issues chained blocks to an external SHA-256 core,
//   builds the single RIPEMD-160 block from the SHA digest, and streams the
//   160-bit result out as 160/OUT_W words, most significant first.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   s_valid/s_ready/s_data     message beat handshake; first byte in the MSBs
//   s_last, s_cnt              last beat marker and its valid byte count
//   sha_start/first/block      block issue to SHA-256 (first = use IV)
//   sha_done/sha_digest        SHA-256 completion and chaining value
//   rmd_start/rmd_block        block issue to RIPEMD-160
//   rmd_done/rmd_digest        RIPEMD-160 completion and result
//   o_valid/o_ready/o_data     result word stream, o_last on final word
//   busy                       high unless idle with an empty buffer

// One byte of the block buffer: computes the next value of buffer byte IDX
// for a beat accepted in FILL, including 0x80 / zero / length padding.
module hash160_buf_lane #(
    parameter int IN_BYTES = 1,
    parameter int IDX      = 0
) (
    input  logic [7:0]            cur,
    input  logic [6:0]            ptr,
    input  logic [6:0]            ptr_nx,
    input  logic                  last_beat,
    input  logic                  short_msg,
    input  logic [8*IN_BYTES-1:0] beat,
    input  logic [7:0]            len_byte,
    output logic [7:0]            nxt
);
    localparam logic [6:0] K = 7'(IDX);

    always_comb begin
        nxt = cur;
        // Data bytes land in [ptr, ptr_nx); ptr is beat-aligned so ptr+j never wraps.
        for (int j = 0; j < IN_BYTES; j++) begin
            if (K == ptr + 7'(j) && K < ptr_nx)
                nxt = beat[8*(IN_BYTES-1-j) +: 8];
        end
        if (last_beat) begin
            if (K == ptr_nx)
                nxt = 8'h80;
            else if (K > ptr_nx)
                nxt = short_msg ? len_byte : 8'h00;
        end
    end
endmodule

module hash160_stream_ctrl #(
    parameter int IN_BYTES = 1,
    parameter int OUT_W    = 32,
    parameter int LEN_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [8*IN_BYTES-1:0]     s_data,
    input  logic                      s_last,
    input  logic [$clog2(IN_BYTES):0] s_cnt,
    output logic                      sha_start,
    output logic                      sha_first,
    output logic [511:0]              sha_block,
    input  logic                      sha_done,
    input  logic [255:0]              sha_digest,
    output logic                      rmd_start,
    output logic [511:0]              rmd_block,
    input  logic                      rmd_done,
    input  logic [159:0]              rmd_digest,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [OUT_W-1:0]          o_data,
    output logic                      o_last,
    output logic                      busy
);
    localparam int NWORDS = 160 / OUT_W;
    localparam int CNT_W  = $clog2(NWORDS + 1);

    typedef enum logic [2:0] {IDLE, FILL, SHA_RUN, PAD, RMD_RUN, OUT} state_t;

    state_t            state;
    logic [63:0][7:0]  blk_q;      // byte 0 of the block sits in blk_q[63]
    logic [63:0][7:0]  blk_nx;
    logic [6:0]        ptr_q;
    logic [LEN_W-1:0]  len_q;
    logic              first_q;
    logic              final_q;
    logic              pad_pend;
    logic              pad80;
    logic [159:0]      shreg;
    logic [CNT_W-1:0]  wcnt;

    logic [6:0]        beat_n;
    logic [6:0]        ptr_nx;
    logic [LEN_W-1:0]  len_nx;
    logic [63:0]       bitlen_nx;
    logic [511:0]      pad_blk;

    assign beat_n    = s_last ? 7'(s_cnt) : 7'(IN_BYTES);
    assign ptr_nx    = ptr_q + beat_n;
    assign len_nx    = len_q + LEN_W'(beat_n);
    assign bitlen_nx = 64'({len_nx, 3'b000});
    // Overflow block: only the optional 0x80 and the length, len already final.
    assign pad_blk   = {(pad80 ? 8'h80 : 8'h00), 440'd0, 64'({len_q, 3'b000})};

    for (genvar k = 0; k < 64; k++) begin : g_lane
        logic [7:0] len_byte;
        if (k >= 56) begin : g_len
            assign len_byte = bitlen_nx[8*(63-k) +: 8];
        end else begin : g_zero
            assign len_byte = 8'h00;
        end
        hash160_buf_lane #(.IN_BYTES(IN_BYTES), .IDX(k)) u_lane (
            .cur       (blk_q[63-k]),
            .ptr       (ptr_q),
            .ptr_nx    (ptr_nx),
            .last_beat (s_last),
            .short_msg (ptr_nx <= 7'd55),
            .beat      (s_data),
            .len_byte  (len_byte),
            .nxt       (blk_nx[63-k])
        );
    end

    assign sha_block = blk_q;
    assign s_ready   = (state == FILL);
    assign busy      = !((state == IDLE) || (state == FILL && ptr_q == 7'd0));
    assign o_data    = shreg[159 -: OUT_W];
    assign o_last    = o_valid && (wcnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            blk_q     <= '0;
            ptr_q     <= '0;
            len_q     <= '0;
            first_q   <= 1'b1;
            final_q   <= 1'b0;
            pad_pend  <= 1'b0;
            pad80     <= 1'b0;
            shreg     <= '0;
            wcnt      <= '0;
            sha_start <= 1'b0;
            sha_first <= 1'b0;
            rmd_start <= 1'b0;
            rmd_block <= '0;
            o_valid   <= 1'b0;
        end else begin
            sha_start <= 1'b0;
            rmd_start <= 1'b0;
            case (state)
                IDLE: state <= FILL;
                FILL: begin
                    if (s_valid) begin
                        blk_q <= blk_nx;
                        len_q <= len_nx;
                        ptr_q <= ptr_nx;
                        if (s_last || ptr_nx == 7'd64) begin
                            sha_start <= 1'b1;
                            sha_first <= first_q;
                            first_q   <= 1'b0;
                            final_q   <= s_last && (ptr_nx <= 7'd55);
                            pad_pend  <= s_last && (ptr_nx >= 7'd56);
                            pad80     <= s_last && (ptr_nx == 7'd64);
                            state     <= SHA_RUN;
                        end
                    end
                end
                SHA_RUN: begin
                    if (sha_done) begin
                        if (final_q) begin
                            rmd_block <= {64'd256, 191'd0, 1'b1, sha_digest};
                            rmd_start <= 1'b1;
                            state     <= RMD_RUN;
                        end else if (pad_pend) begin
                            state <= PAD;
                        end else begin
                            ptr_q <= '0;
                            state <= FILL;
                        end
                    end
                end
                PAD: begin
                    blk_q     <= pad_blk;
                    sha_start <= 1'b1;
                    sha_first <= first_q;
                    final_q   <= 1'b1;
                    pad_pend  <= 1'b0;
                    state     <= SHA_RUN;
                end
                RMD_RUN: begin
                    if (rmd_done) begin
                        shreg   <= rmd_digest;
                        wcnt    <= CNT_W'(NWORDS);
                        o_valid <= 1'b1;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    if (o_ready) begin
                        shreg <= shreg << OUT_W;
                        wcnt  <= wcnt - CNT_W'(1);
                        if (wcnt == CNT_W'(1)) begin
                            o_valid <= 1'b0;
                            len_q   <= '0;
                            ptr_q   <= '0;
                            first_q <= 1'b1;
                            state   <= FILL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/hash160_stream_ctrl.md
# hash160_stream_ctrl

Parametrised HASH160 front-end and sequencer that sits between a byte-stream source and the team's SHA-256 and RIPEMD-160 cores. It accepts messages of any length over a valid/ready stream, `IN_BYTES` bytes per beat, and applies SHA-256 padding on the fly. It issues chained 512-bit blocks to SHA-256, forms the fixed RIPEMD-160 block from the 256-bit digest, and returns the 160-bit result as `160/OUT_W` words with output backpressure. Unlike the fixed 64-byte, 8-bit-in / 32-bit-out top, it handles multi-block messages, variable beat width, output width and a ready handshake.

## Interface
Parameters:
- `IN_BYTES`, 1: bytes per input beat. Legal values are 1, 2, 4, 8.
- `OUT_W`, 32: output word width. Legal values are 8, 16, 32, 160.
- `LEN_W`, 32: width of the message byte counter. Bit length is `{len,3'b0}`, zero-extended to 64 bits.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `s_valid`  in  1: input beat valid.
- `s_ready`  out  1: input beat accepted when `s_valid` and `s_ready` are both high.
- `s_data`  in  8*IN_BYTES: message bytes. The first byte is in the MSBs.
- `s_last`  in  1: final beat of the message.
- `s_cnt`  in  clog2(IN_BYTES)+1: number of valid bytes on the last beat, 1..IN_BYTES. Ignored on beats that are not last.
- `sha_start`  out  1: one-cycle pulse; `sha_block` is valid on this cycle.
- `sha_first`  out  1: qualifies `sha_start`. 1 selects the IV, 0 chains from the previous digest.
- `sha_block`  out  512: SHA-256 message block, big-endian.
- `sha_done`  in  1: pulse from the core; `sha_digest` is valid.
- `sha_digest`  in  256: SHA-256 chaining value / final digest.
- `rmd_start`  out  1: one-cycle pulse.
- `rmd_block`  out  512: `{64'd256, 191'b0, 1'b1, sha_digest_reg}`.
- `rmd_done`  in  1: pulse from the core.
- `rmd_digest`  in  160: RIPEMD-160 result.
- `o_valid`  out  1: output word valid.
- `o_ready`  in  1: output word accepted.
- `o_data`  out  OUT_W: result word, most significant word first.
- `o_last`  out  1: marks the final word.
- `busy`  out  1: high in every state except `IDLE` and `FILL` with an empty buffer.

## Operation
State machine: `IDLE`, `FILL`, `SHA_RUN`, `PAD`, `RMD_RUN`, `OUT`.
- `IDLE`: entered on reset. Moves to `FILL` on the next cycle unconditionally.
- `FILL`: `s_ready`=1. Each accepted beat writes its bytes at the byte pointer `ptr` (0..63) of a 64-byte buffer and adds `IN_BYTES` (or `s_cnt` on the last beat) to `len`.
  - Buffer full and `s_last`=0: issue the block with `final`=0, go to `SHA_RUN`.
  - Last beat with final `ptr`=p: write 0x80 at p and zero bytes p+1..63.
    - p≤55: write the 64-bit bit length into bytes 56..63, issue with `final`=1.
    - 56≤p≤63: issue with `final`=0 and set `pad_pending`.
    - Last beat fills the buffer exactly (p=64): issue the block as data and set `pad_pending` with `pad80`=1.
- `SHA_RUN`: wait for `sha_done`. Latch `sha_digest` on it.
  - `final`: go to `RMD_RUN` and pulse `rmd_start` on the next cycle.
  - `pad_pending`: go to `PAD`.
  - Otherwise: return to `FILL` with `ptr`=0.
- `PAD`: build a block of zeros. If `pad80`, byte 0 = 0x80. Bytes 56..63 = bit length. Issue with `final`=1, go to `SHA_RUN`.
- `RMD_RUN`: wait for `rmd_done`. Load `rmd_digest` into a 160-bit shift register and the word counter, go to `OUT`.
- `OUT`: `o_valid`=1 and `o_data`=shreg[159 -: OUT_W].
  - On each handshake: shift left by OUT_W and decrement the counter.
  - `o_last`=1 when the counter equals 1.
  - Handshake with `o_last`: clear `len`, `ptr`, `first` and go to `FILL`.
- `sha_first` is 1 for the first block of each message and 0 afterwards.
- `sha_done` is ignored outside `SHA_RUN` and `rmd_done` outside `RMD_RUN`.
- `len` wraps modulo 2^LEN_W with no error flag.

## Timing
- Reset values: every output is 0 and the state is `IDLE`. Reset asserted mid-message discards all state, including a partial message or pending output, and `o_valid` drops asynchronously.
- `s_ready` is decoded from registered state only; it has no combinational path from `s_valid`. It goes low on the cycle after the beat that fills the buffer or carries `s_last`.
- `sha_start` is asserted one cycle after the completing beat, or one cycle after entering `PAD`. `sha_block` is held stable until `sha_done`.
- `rmd_start` is asserted one cycle after `sha_done` of the final block.
- The first `o_valid` is asserted one cycle after `rmd_done`. `o_data` holds while `o_ready`=0.
- The next message's first beat can be accepted one cycle after the `o_last` handshake.

## Test plan
- IN_BYTES=1, OUT_W=32, "abc" (0x61,0x62,0x63 with `s_last`): one `sha_start` with `sha_first`=1, block 0x61626380 followed by zeros, and last word 0x00000018. Output words bb1be98c, 142444d7, a56aa398, 1c3942a9, 78e4dc33, with `o_last` on the 5th.
- 55-byte message: exactly one SHA block, with length 0x1B8 in bytes 56..63.
- 56-byte message: two blocks. The second has `sha_first`=0, is all zeros, and carries length 0x1C0.
- 64-byte message, IN_BYTES=4: 16 beats then `s_ready`=0. The second block starts 0x80 and carries length 0x200.
- OUT_W=16 with `o_ready` toggling 1,0,0,1…: exactly 10 words in order, `o_data` stable during stalls, `o_last` only on the 10th.
- `rst_n` pulsed low after 20 bytes: all outputs return to 0. A following "abc" message reproduces the vector from the first test.
